// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the unified-memory arbiter.
//   arb_state_t   - arbiter FSM states
//   arb_owner_t   - which port owns the current memory access
//   ARB_CNT_WIDTH - width of the latency counter (MEM_LATENCY up to 15)
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        OWNER_IF,
        OWNER_DM
    } arb_owner_t;

    localparam int ARB_CNT_WIDTH = 4;

endpackage

// File: rtl/mem_arb_latency_counter.sv
// mem_arb_latency_counter: counts memory wait cycles for the arbiter.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   clear       - force count to 0 (asserted while the access is issued)
//   enable      - increment, saturating at MEM_LATENCY-1
//   count       - current count
//   done        - the increment taken this cycle lands on MEM_LATENCY-1, so
//                 the owner of the counter can leave its wait state at this
//                 edge and be in its response state when the data is valid
module mem_arb_latency_counter
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     enable,
    output logic [ARB_CNT_WIDTH-1:0] count,
    output logic                     done
);

    localparam logic [ARB_CNT_WIDTH-1:0] LAST = ARB_CNT_WIDTH'(MEM_LATENCY - 1);

    logic [ARB_CNT_WIDTH-1:0] count_inc;

    assign count_inc = count + ARB_CNT_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count_inc;
        end
    end

    // Already saturated also counts as done so the wait can never hang.
    assign done = enable && ((count_inc == LAST) || (count == LAST));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch (if_*)
// and load/store (dm_*). Grants in IDLE, strobes mem_en for one cycle, waits
// MEM_LATENCY cycles and returns the read data with a one-cycle ready pulse.
// Ports:
//   clk, rst_n                          - clock, synchronous active-low reset
//   if_req/if_addr/if_rdata/if_ready    - fetch port
//   dm_req/dm_we/dm_addr/dm_wdata/
//   dm_rdata/dm_ready                   - data port
//   mem_en/mem_we/mem_addr/mem_wdata/
//   mem_rdata                           - memory macro side
//   stall                               - some requester is still unserved
// Build option: define MEM_ARB_RR_EN for round-robin tie breaking; without it
// data always wins over fetch.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ready,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  dm_ready,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  stall
);

    arb_state_t               state;
    arb_owner_t               owner;
    arb_owner_t               grant;
    logic                     cnt_done;
    // Only the done flag steers the FSM; the raw count stays for debug.
    logic [ARB_CNT_WIDTH-1:0] cnt_unused;

    mem_arb_latency_counter #(
        .MEM_LATENCY(MEM_LATENCY)
    ) u_lat_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state == ARB_ISSUE),
        .enable(state == ARB_WAIT),
        .count (cnt_unused),
        .done  (cnt_done)
    );

`ifdef MEM_ARB_RR_EN
    arb_owner_t last_winner;

    // On a tie the port that lost the previous grant goes first.
    always_comb begin
        grant = OWNER_IF;
        if (dm_req && if_req) begin
            grant = (last_winner == OWNER_IF) ? OWNER_DM : OWNER_IF;
        end else if (dm_req) begin
            grant = OWNER_DM;
        end
    end
`else
    always_comb begin
        grant = OWNER_IF;
        if (dm_req) begin
            grant = OWNER_DM;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            owner     <= OWNER_IF;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ready  <= 1'b0;
            dm_ready  <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_winner <= OWNER_IF;
`endif
        end else begin
            mem_en   <= 1'b0;
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (if_req || dm_req) begin
                        state     <= ARB_ISSUE;
                        owner     <= grant;
                        mem_en    <= 1'b1;
                        mem_we    <= (grant == OWNER_DM) && dm_we;
                        mem_addr  <= (grant == OWNER_DM) ? dm_addr : if_addr;
                        mem_wdata <= (grant == OWNER_DM) ? dm_wdata : '0;
`ifdef MEM_ARB_RR_EN
                        last_winner <= grant;
`endif
                    end
                end
                ARB_ISSUE: begin
                    if (MEM_LATENCY > 1) begin
                        state <= ARB_WAIT;
                    end else begin
                        state    <= ARB_RESP;
                        if_ready <= (owner == OWNER_IF);
                        dm_ready <= (owner == OWNER_DM);
                    end
                end
                ARB_WAIT: begin
                    if (cnt_done) begin
                        state    <= ARB_RESP;
                        if_ready <= (owner == OWNER_IF);
                        dm_ready <= (owner == OWNER_DM);
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    // Ready is high exactly in RESP for the owner, so it also gates the
    // pass-through of the memory data. Stores return zero.
    assign if_rdata = if_ready ? mem_rdata : '0;
    assign dm_rdata = (dm_ready && !mem_we) ? mem_rdata : '0;

    assign stall = (if_req & ~if_ready) | (dm_req & ~dm_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int L  = 2;
    localparam int P  = L + 2;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic [AW-1:0] if_addr = '0, dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic [DW-1:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
    logic          if_ready, dm_ready, mem_en, mem_we, stall;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall(stall)
    );

    // Memory macro: word array, read data valid L cycles after mem_en,
    // random junk on every other cycle.
    logic [31:0] sim_mem [0:4095];
    logic [31:0] rpipe [1:L];

    always @(posedge clk) begin
        if (mem_en && mem_we) sim_mem[mem_addr[13:2]] <= mem_wdata;
        rpipe[1] <= (mem_en && !mem_we) ? sim_mem[mem_addr[13:2]] : $urandom;
        for (int k = 2; k <= L; k++) rpipe[k] <= rpipe[k-1];
    end
    assign mem_rdata = rpipe[L];

    // Reference model: what each address should hold from the ports' view.
    logic [31:0] ref_mem [0:4095];
    logic [31:0] if_q[$];
    logic [31:0] dm_q[$];
    int pass_cnt = 0;
    int fail_cnt = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Monitor: pops expectations whenever a ready pulse appears.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("stall", {31'b0, stall}, {31'b0, (if_req && !if_ready) || (dm_req && !dm_ready)});
            if (if_ready) begin
                if (if_q.size() == 0) begin
                    fail_cnt++;
                    $display("FAIL if_ready unexpected: got 1 expected 0 (t=%0t)", $time);
                end else chk("if_rdata", if_rdata, if_q.pop_front());
            end
            if (dm_ready) begin
                if (dm_q.size() == 0) begin
                    fail_cnt++;
                    $display("FAIL dm_ready unexpected: got 1 expected 0 (t=%0t)", $time);
                end else chk("dm_rdata", dm_rdata, dm_q.pop_front());
            end
        end
    end

    // One isolated access starting in an IDLE cycle (cycle 0 = now).
    task automatic single(input bit is_dm, input bit we, input logic [31:0] addr,
                          input logic [31:0] wd);
        logic [31:0] exp;
        int idx;
        idx = int'(addr[13:2]);
        if (is_dm) begin
            dm_req = 1; dm_we = we; dm_addr = addr; dm_wdata = wd;
            if (we) begin ref_mem[idx] = wd; exp = 0; end
            else exp = ref_mem[idx];
            dm_q.push_back(exp);
        end else begin
            if_req = 1; if_addr = addr;
            exp = ref_mem[idx];
            if_q.push_back(exp);
        end
        smp(); chk("single stall c0", {31'b0, stall}, 1);
        next(); smp();
        chk("single mem_en", {31'b0, mem_en}, 1);
        chk("single mem_addr", mem_addr, addr);
        chk("single mem_we", {31'b0, mem_we}, {31'b0, we});
        if (we) chk("single mem_wdata", mem_wdata, wd);
        repeat (L - 1) begin
            next(); smp();
            chk("single early ready", {31'b0, is_dm ? dm_ready : if_ready}, 0);
            chk("single mem_en pulse", {31'b0, mem_en}, 0);
        end
        next(); smp();
        chk("single ready", {31'b0, is_dm ? dm_ready : if_ready}, 1);
        chk("single rdata", is_dm ? dm_rdata : if_rdata, exp);
        chk("single stall at ready", {31'b0, stall}, 0);
        next();
        if_req = 0; dm_req = 0; dm_we = 0;
    endtask

    task automatic fetch_agent(input int n);
        logic [31:0] a;
        bit ok;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) next();
            a = {18'b0, 12'($urandom_range(0, 2047)), 2'b00};
            if_addr = a; if_req = 1;
            if_q.push_back(ref_mem[a[13:2]]);
            ok = 0;
            for (int t = 0; t < 4 * P + 4; t++) begin
                smp();
                if (if_ready) begin ok = 1; break; end
            end
            if (!ok) begin
                fail_cnt++;
                $display("FAIL fetch timeout: got no if_ready expected if_ready addr %h", a);
            end
            next(); if_req = 0;
        end
    endtask

    task automatic data_agent(input int n);
        logic [31:0] a, wd;
        bit we, ok;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(1, 3)) next();
            a = {18'b0, 12'($urandom_range(2048, 4095)), 2'b00};
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            dm_addr = a; dm_we = we; dm_wdata = wd; dm_req = 1;
            if (we) begin ref_mem[a[13:2]] = wd; dm_q.push_back(0); end
            else dm_q.push_back(ref_mem[a[13:2]]);
            ok = 0;
            for (int t = 0; t < 4 * P + 4; t++) begin
                smp();
                if (dm_ready) begin ok = 1; break; end
            end
            if (!ok) begin
                fail_cnt++;
                $display("FAIL data timeout: got no dm_ready expected dm_ready addr %h", a);
            end
            next(); dm_req = 0; dm_we = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_addr [4];
        int rc;
        for (int i = 0; i < 4096; i++) begin
            sim_mem[i] = 32'h9E3779B9 * i + 32'h1234;
            ref_mem[i] = 32'h9E3779B9 * i + 32'h1234;
        end
        sim_mem[32'h100 >> 2] = 32'h00500093;
        ref_mem[32'h100 >> 2] = 32'h00500093;

        // Reset state
        repeat (3) next();
        smp();
        chk("rst mem_en", {31'b0, mem_en}, 0);
        chk("rst mem_we", {31'b0, mem_we}, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        chk("rst if_ready", {31'b0, if_ready}, 0);
        chk("rst dm_ready", {31'b0, dm_ready}, 0);
        chk("rst if_rdata", if_rdata, 0);
        chk("rst dm_rdata", dm_rdata, 0);
        next(); rst_n = 1; mon_en = 1;
        next();

        // Fetch, store, load-back of the stored word
        single(0, 0, 32'h100, 0);
        single(1, 1, 32'h2000, 32'hDEADBEEF);
        single(1, 0, 32'h2000, 0);

        // Tie: data first, fetch granted in the IDLE after data's RESP
        if_req = 1; if_addr = 32'h104;
        dm_req = 1; dm_we = 0; dm_addr = 32'h2004;
        if_q.push_back(ref_mem[32'h104 >> 2]);
        dm_q.push_back(ref_mem[32'h2004 >> 2]);
        for (int c = 0; c <= 2 * L + 3; c++) begin
            if (c > 0) next();
            if (c == L + 2) dm_req = 0;
            smp();
            if (c == 1) begin
                chk("tie dm mem_en", {31'b0, mem_en}, 1);
                chk("tie dm mem_addr", mem_addr, 32'h2004);
            end
            if (c == L + 1) chk("tie dm_ready", {31'b0, dm_ready}, 1);
            if (c == L + 3) begin
                chk("tie if mem_en", {31'b0, mem_en}, 1);
                chk("tie if mem_addr", mem_addr, 32'h104);
            end
            if (c == 2 * L + 3) chk("tie if_ready", {31'b0, if_ready}, 1);
        end
        next(); if_req = 0;
        next();

        // Sustained data requests with a pending fetch: grant order
        exp_addr[0] = 32'h2008;
        exp_addr[1] = RR ? 32'h108 : 32'h2008;
        exp_addr[2] = 32'h2008;
        exp_addr[3] = 32'h108;
        repeat (RR ? 2 : 3) dm_q.push_back(ref_mem[32'h2008 >> 2]);
        repeat (RR ? 2 : 1) if_q.push_back(ref_mem[32'h108 >> 2]);
        dm_req = 1; dm_we = 0; dm_addr = 32'h2008;
        if_req = 1; if_addr = 32'h108;
        for (int c = 0; c < 4 * P; c++) begin
            if (c > 0) next();
            if (c == 3 * P) dm_req = 0;
            smp();
            if (c == 1 || c == 1 + P || c == 1 + 2 * P || c == 3 * P + 1) begin
                chk("order mem_en", {31'b0, mem_en}, 1);
                chk("order mem_addr", mem_addr, exp_addr[(c - 1) / P]);
            end
            if (c == 2 * P - 1) chk("order if_ready mid", {31'b0, if_ready}, {31'b0, RR});
            if (c == 4 * P - 1) chk("order if_ready end", {31'b0, if_ready}, 1);
        end
        next(); if_req = 0;
        next();

        // Reset in the middle of a load: no response ever
        rc = (L >= 2) ? 2 : 1;
        dm_req = 1; dm_we = 0; dm_addr = 32'h200C;
        smp();
        for (int c = 1; c <= rc; c++) begin
            next();
            if (c == rc) rst_n = 0;
            smp();
            if (c == 1) chk("rstmid mem_en", {31'b0, mem_en}, 1);
        end
        next(); rst_n = 1; dm_req = 0;
        smp();
        chk("rstmid mem_en", {31'b0, mem_en}, 0);
        chk("rstmid mem_we", {31'b0, mem_we}, 0);
        chk("rstmid mem_addr", mem_addr, 0);
        chk("rstmid mem_wdata", mem_wdata, 0);
        chk("rstmid dm_ready", {31'b0, dm_ready}, 0);
        chk("rstmid dm_rdata", dm_rdata, 0);
        chk("rstmid if_ready", {31'b0, if_ready}, 0);
        repeat (2 * L + 2) begin
            next(); smp();
            chk("rstmid no dm_ready", {31'b0, dm_ready}, 0);
        end
        next();

        // Random traffic on both ports
        fork
            fetch_agent(60);
            data_agent(60);
        join
        repeat (P + 2) next();
        chk("if_q drained", if_q.size(), 0);
        chk("dm_q drained", dm_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates one single-port unified memory between the instruction-fetch port and the load/store data port of the RV32I core. It latches the winning request and drives the memory for a fixed-latency access. It returns the read data with a one-cycle ready pulse and raises a combined stall so the control path freezes the PC and register writeback until both ports are served. It sits between the fetch/data-memory interfaces of the datapath and the memory macro.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width
- MEM_LATENCY, 2, cycles from the mem_en cycle to valid mem_rdata; legal range 1..15
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  ADDR_WIDTH  fetch address, stable while if_req high
- if_rdata  out  DATA_WIDTH  fetch data, valid only when if_ready=1
- if_ready  out  1  one-cycle fetch completion pulse
- dm_req  in  1  data request, held until dm_ready
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_WIDTH  data address
- dm_wdata  in  DATA_WIDTH  store data
- dm_rdata  out  DATA_WIDTH  load data, valid only when dm_ready=1
- dm_ready  out  1  one-cycle data completion pulse
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  ADDR_WIDTH  registered access address
- mem_wdata  out  DATA_WIDTH  registered write data
- mem_rdata  in  DATA_WIDTH  memory read data
- stall  out  1  (if_req & ~if_ready) | (dm_req & ~dm_ready), combinational

## Operation
- FSM states and transitions:
  - IDLE: if any req, go to ISSUE; otherwise stay.
  - ISSUE: go to WAIT if MEM_LATENCY>1, else to RESP.
  - WAIT: when the counter reaches MEM_LATENCY-1, go to RESP.
  - RESP: always go to IDLE.
- Arbitration happens in IDLE only. Default is data-first: if dm_req=1, grant data, else grant fetch.
- At grant, latch the grant owner, address, we (forced 0 for fetch) and wdata into mem_addr/mem_we/mem_wdata. The registers hold until the next grant.
- ISSUE: mem_en=1 for exactly one cycle.
- WAIT: the latency counter increments each cycle, is cleared in ISSUE and saturates at MEM_LATENCY-1.
- RESP:
  - Pulse the owner's ready for one cycle.
  - Owner rdata = mem_rdata in this cycle. The non-owner rdata is 0.
  - Stores also pulse dm_ready in RESP; dm_rdata is 0 for stores.
- Requests are not sampled in RESP or ISSUE/WAIT. A requester that sees ready drops req next cycle unless it has a new access.
- Reset, including mid-access: state = IDLE, counter = 0, owner = fetch. mem_en, mem_we, if_ready and dm_ready are 0; mem_addr, mem_wdata, if_rdata and dm_rdata are 0. Any in-flight memory response is discarded.
- Req deassertion while not yet granted is legal: no access is issued. Deassertion after grant is illegal; the access still completes and the ready is still pulsed.

## Timing
- Req high in IDLE at cycle 0 → mem_en at cycle 1 → ready at cycle 1+MEM_LATENCY. This gives latency MEM_LATENCY+1.
- Back-to-back throughput is one access per MEM_LATENCY+2 cycles, because of the mandatory IDLE after RESP.
- Simultaneous if_req and dm_req in IDLE: data is served first. Fetch is granted in the IDLE cycle after data's RESP, and fetch ready arrives 2·(MEM_LATENCY+2)-1 cycles after cycle 0.
- stall has no register delay and is low in the ready cycle of the last outstanding requester.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration. On simultaneous requests the port that did not win the previous grant wins. After reset, fetch counts as the last winner, so data wins the first tie.
- MEM_ARB_RR_EN undefined: strict data-first. Fetch can starve while dm_req stays asserted.

## Structure
- The shared package holds:
  - typedef enum arb_state_t {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP}
  - typedef enum arb_owner_t {OWNER_IF, OWNER_DM}
  - constant ARB_CNT_WIDTH = 4
- One sub-module, mem_arb_latency_counter: clear, enable, count output and done flag at MEM_LATENCY-1.

## Test plan
- MEM_LATENCY=2, fetch only: if_addr=0x100, mem_rdata=0x00500093 at cycle 3 → mem_en at cycle 1 with mem_addr=0x100; if_ready=1 at cycle 3 with if_rdata=0x00500093; stall=1 for cycles 0..2.
- Store: dm_we=1, dm_addr=0x2000, dm_wdata=0xDEADBEEF → mem_en=1 and mem_we=1 at cycle 1 with that address/data; dm_ready at cycle 3 with dm_rdata=0.
- Tie at cycle 0: if_addr=0x104, dm_addr=0x2004 load → data access at cycle 1, dm_ready at cycle 3; fetch mem_en at cycle 5, if_ready at cycle 7.
- With MEM_ARB_RR_EN, dm_req held high plus if_req → grants alternate DM, IF, DM. Without the macro, if_ready never fires while dm_req stays high.
- rst_n=0 at cycle 2 of a load → cycle 3 shows IDLE and all outputs 0; no dm_ready is ever pulsed for that load.
- MEM_LATENCY=1 build, fetch 0x0 → WAIT state skipped, if_ready at cycle 2.
